// File: rtl/gate_bank_bist_if.sv
// Bundle of the gate-bank operand, function, BIST control and result signals.
// The master drives operands and requests; the slave (the gate bank) returns results.
interface gate_bank_bist_if #(
  parameter int CHANNELS = 4
);
  logic                ena;
  logic [1:0]          mode;
  logic [CHANNELS-1:0] a;
  logic [CHANNELS-1:0] b;
  logic [CHANNELS-1:0] fault_mask;
  logic [CHANNELS-1:0] y;
  logic                bist_start;
  logic                bist_busy;
  logic                bist_done;
  logic                bist_pass;
  logic [CHANNELS-1:0] fail_chan;

  modport master (
    output ena, mode, a, b, fault_mask, bist_start,
    input  y, bist_busy, bist_done, bist_pass, fail_chan
  );

  modport slave (
    input  ena, mode, a, b, fault_mask, bist_start,
    output y, bist_busy, bist_done, bist_pass, fail_chan
  );
endinterface

// File: rtl/gate_bank_bist.sv
// Bank of CHANNELS two-input gates (AND/OR/XOR/NAND) with registered outputs and
// a 16-vector self-test; 1-cycle latency, ena stalls everything including the BIST.
module gate_bank_bist #(
  parameter int CHANNELS = 4
) (
  input  logic              clk,
  input  logic              rst,
  gate_bank_bist_if.slave   bus_if
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  // Expected gate output indexed by {mode, b, a}; kept apart from the datapath on purpose.
  localparam logic [15:0] GOLDEN_LUT = 16'h76E8;

  logic [1:0]          state_q, state_d;
  logic [3:0]          vec_q, vec_d;
  logic [CHANNELS-1:0] y_q, y_d;
  logic [CHANNELS-1:0] exp_q, exp_d;
  logic [CHANNELS-1:0] fail_q, fail_d;
  logic                cmp_valid_q, cmp_valid_d;
  logic                pass_q, pass_d;
  logic                done_q, done_d;

  logic                in_run;
  logic [1:0]          mode_eff;
  logic [CHANNELS-1:0] a_eff, b_eff;
  logic [CHANNELS-1:0] gate_raw, gate_out;
  logic [CHANNELS-1:0] mism;

  always_comb begin
    in_run   = (state_q == RUN);
    mode_eff = in_run ? vec_q[3:2] : bus_if.mode;
    a_eff    = in_run ? {CHANNELS{vec_q[0]}} : bus_if.a;
    b_eff    = in_run ? {CHANNELS{vec_q[1]}} : bus_if.b;
    case (mode_eff)
      2'b00:   gate_raw = a_eff & b_eff;
      2'b01:   gate_raw = a_eff | b_eff;
      2'b10:   gate_raw = a_eff ^ b_eff;
      default: gate_raw = ~(a_eff & b_eff);
    endcase
    gate_out = gate_raw ^ bus_if.fault_mask;
    mism     = y_q ^ exp_q;
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    y_d         = y_q;
    exp_d       = exp_q;
    fail_d      = fail_q;
    cmp_valid_d = cmp_valid_q;
    pass_d      = pass_q;
    done_d      = 1'b0;

    // Comparison runs one cycle behind capture, so it also covers the DRAIN edge.
    if (cmp_valid_q) begin
      fail_d = fail_q | mism;
    end

    case (state_q)
      IDLE: begin
        y_d = gate_out;
        if (bus_if.bist_start) begin
          state_d = RUN;
          vec_d   = 4'd0;
          fail_d  = '0;
          pass_d  = 1'b0;
        end
      end
      RUN: begin
        y_d         = gate_out;
        exp_d       = {CHANNELS{GOLDEN_LUT[vec_q]}};
        cmp_valid_d = 1'b1;
        vec_d       = vec_q + 4'd1;
        if (vec_q == 4'd15) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cmp_valid_d = 1'b0;
        pass_d      = ((fail_q | mism) == '0);
        done_d      = 1'b1;
        state_d     = IDLE;
      end
      default: begin
        state_d     = IDLE;
        cmp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      vec_q       <= 4'd0;
      y_q         <= '0;
      exp_q       <= '0;
      fail_q      <= '0;
      cmp_valid_q <= 1'b0;
      pass_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (bus_if.ena) begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      y_q         <= y_d;
      exp_q       <= exp_d;
      fail_q      <= fail_d;
      cmp_valid_q <= cmp_valid_d;
      pass_q      <= pass_d;
      done_q      <= done_d;
    end
  end

  assign bus_if.y         = y_q;
  assign bus_if.bist_busy = (state_q != IDLE);
  assign bus_if.bist_done = done_q;
  assign bus_if.bist_pass = pass_q;
  assign bus_if.fail_chan = fail_q;

endmodule

// File: tb/tb_gate_bank_bist.sv
// Scoreboard bench for gate_bank_bist: driver pushes expectations, a negedge monitor
// pops and compares them against y/status slots and against each bist_done pulse.
module tb_gate_bank_bist;
  localparam int CH = 4;

  logic clk;
  logic rst;
  gate_bank_bist_if #(.CHANNELS(CH)) bif ();

  gate_bank_bist #(.CHANNELS(CH)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int            cyc;
    bit            chk_y;
    logic [CH-1:0] y;
    bit            chk_st;
    logic          busy;
    logic          done;
    logic          pass;
    logic [CH-1:0] fail;
  } exp_t;

  typedef struct {
    logic          pass;
    logic [CH-1:0] fail;
    logic [CH-1:0] y;
    int            len;
  } bist_t;

  exp_t  eq[$];
  bist_t bq[$];
  int    cyc = 0;
  int    done_cnt = 0;
  int    timeouts = 0;
  bit    finished = 1'b0;
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [CH-1:0] model_y;

  always @(posedge clk) cyc = cyc + 1;

  // Plain-operator reference for one gate.
  function automatic logic tt(input logic [1:0] m, input logic a, input logic b);
    case (m)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return !(a & b);
    endcase
  endfunction

  function automatic logic [CH-1:0] model_gate(input logic [1:0] m, input logic [CH-1:0] a,
                                               input logic [CH-1:0] b, input logic [CH-1:0] fm);
    logic [CH-1:0] r;
    for (int i = 0; i < CH; i++) r[i] = tt(m, a[i], b[i]) ^ fm[i];
    return r;
  endfunction

  function automatic bist_t model_bist(input logic [CH-1:0] fm, input int stall);
    bist_t         r;
    logic [3:0]    v;
    logic          gold;
    r.fail = '0;
    for (int k = 0; k < 16; k++) begin
      v = 4'(k);
      gold = tt(v[3:2], v[0], v[1]);
      for (int c = 0; c < CH; c++)
        if ((gold ^ fm[c]) != gold) r.fail[c] = 1'b1;
    end
    r.pass = (r.fail == '0);
    r.y    = {CH{tt(2'b11, 1'b1, 1'b1)}} ^ fm;
    r.len  = 17 + stall;
    return r;
  endfunction

  // ---------------- monitor ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t  e;
    bist_t be;
    int    busy_cnt;
    logic  prev_done;
    busy_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) busy_cnt = 0;
      else if (bif.bist_busy === 1'b1) busy_cnt++;
      while (eq.size() > 0 && eq[0].cyc <= cyc) begin
        e = eq.pop_front();
        chk("slot_order", e.cyc, cyc);
        if (e.chk_y) chk("y", bif.y, e.y);
        if (e.chk_st) begin
          chk("busy", bif.bist_busy, e.busy);
          chk("done", bif.bist_done, e.done);
          chk("pass", bif.bist_pass, e.pass);
          chk("fail_chan", bif.fail_chan, e.fail);
        end
      end
      if (bif.bist_done === 1'b1) begin
        if (bq.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          be = bq.pop_front();
          chk("bist_pass", bif.bist_pass, be.pass);
          chk("bist_fail_chan", bif.fail_chan, be.fail);
          chk("bist_y_last_vec", bif.y, be.y);
          chk("bist_busy_len", busy_cnt, be.len);
          chk("busy_at_done", bif.bist_busy, 1'b0);
          chk("done_single_pulse", prev_done, 1'b0);
        end
        done_cnt++;
        busy_cnt = 0;
      end
      prev_done = bif.bist_done;
      if (finished) begin
        chk("bist_timeouts", timeouts, 0);
        chk("pending_slots", eq.size(), 0);
        chk("pending_bist", bq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- driver ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_y(input int c, input logic [CH-1:0] y);
    exp_t e;
    e = '{cyc: c, chk_y: 1'b1, y: y, chk_st: 1'b0, busy: 1'b0, done: 1'b0, pass: 1'b0, fail: '0};
    eq.push_back(e);
  endtask

  task automatic push_reset_state(input int c, input bit with_y);
    exp_t e;
    e = '{cyc: c, chk_y: with_y, y: '0, chk_st: 1'b1, busy: 1'b0, done: 1'b0, pass: 1'b0, fail: '0};
    eq.push_back(e);
  endtask

  task automatic drive_norm(input logic [CH-1:0] a, input logic [CH-1:0] b, input logic [1:0] m,
                            input logic [CH-1:0] fm, input logic en);
    step();
    bif.a = a; bif.b = b; bif.mode = m; bif.fault_mask = fm; bif.ena = en;
    bif.bist_start = 1'b0;
    if (en) model_y = model_gate(m, a, b, fm);
    push_y(cyc + 1, model_y);
  endtask

  task automatic run_bist(input logic [CH-1:0] fm, input int stall, input bit restart_mid);
    int d0;
    d0 = done_cnt;
    step();
    bif.fault_mask = fm; bif.ena = 1'b1; bif.bist_start = 1'b1;
    bif.a = CH'($urandom); bif.b = CH'($urandom); bif.mode = 2'($urandom);
    bq.push_back(model_bist(fm, stall));
    for (int k = 0; k < 12; k++) begin
      step();
      bif.bist_start = (restart_mid && k == 3);
      bif.ena = !(stall > 0 && k >= 5 && k < 5 + stall);
      bif.a = CH'($urandom); bif.b = CH'($urandom); bif.mode = 2'($urandom);
    end
    bif.ena = 1'b1;
    bif.bist_start = 1'b0;
    for (int k = 0; k < 80 && done_cnt == d0; k++) step();
    if (done_cnt == d0) timeouts++;
    model_y = model_bist(fm, stall).y;
  endtask

  initial begin : driver
    rst = 1'b1;
    bif.ena = 1'($urandom); bif.a = CH'($urandom); bif.b = CH'($urandom);
    bif.mode = 2'($urandom); bif.fault_mask = CH'($urandom); bif.bist_start = 1'($urandom);
    model_y = '0;
    step(); push_reset_state(cyc, 1'b1);
    bif.bist_start = 1'($urandom); bif.a = CH'($urandom);
    step(); push_reset_state(cyc, 1'b1);
    rst = 1'b0; bif.bist_start = 1'b0; bif.ena = 1'b1; bif.fault_mask = '0;

    drive_norm(4'b1100, 4'b1010, 2'b00, 4'b0000, 1'b1);
    drive_norm(4'b1100, 4'b1010, 2'b01, 4'b0000, 1'b1);
    drive_norm(4'b1100, 4'b1010, 2'b10, 4'b0000, 1'b1);
    drive_norm(4'b1100, 4'b1010, 2'b11, 4'b0000, 1'b1);
    drive_norm(4'b1100, 4'b1010, 2'b00, 4'b0001, 1'b1);
    drive_norm(4'b1100, 4'b1010, 2'b00, 4'b0000, 1'b1);
    drive_norm(4'b0011, 4'b0101, 2'b01, 4'b0000, 1'b0);
    drive_norm(4'b1111, 4'b1111, 2'b11, 4'b1111, 1'b0);
    drive_norm(4'b1100, 4'b1010, 2'b01, 4'b0000, 1'b1);

    for (int i = 0; i < 40; i++)
      drive_norm(CH'($urandom), CH'($urandom), 2'($urandom), CH'($urandom), ($urandom_range(0, 3) != 0));

    run_bist(4'b0000, 0, 1'b1);
    run_bist(4'b0100, 0, 1'b0);
    run_bist(4'b0100, 3, 1'b0);
    drive_norm(4'b0110, 4'b0011, 2'b10, 4'b0000, 1'b1);
    run_bist(4'b0000, 0, 1'b0);

    step(); bif.bist_start = 1'b1;
    step(); bif.bist_start = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    push_reset_state(cyc + 1, 1'b1);
    step(); rst = 1'b0;
    repeat (25) step();
    push_reset_state(cyc, 1'b0);
    run_bist(4'b0000, 0, 1'b0);

    for (int i = 0; i < 3; i++)
      run_bist(CH'($urandom), $urandom_range(0, 4), 1'($urandom));
    for (int i = 0; i < 10; i++)
      drive_norm(CH'($urandom), CH'($urandom), 2'($urandom), CH'($urandom), 1'b1);

    repeat (3) step();
    finished = 1'b1;
  end

endmodule
